// File: rtl/fifo_rd_stream_adapter_if.sv
// FIFO read port plus downstream valid/ready stream seen by fifo_rd_stream_adapter.
// master = the adapter (drives rd_en and the stream), slave = FIFO + downstream sink.
interface fifo_rd_stream_adapter_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  fifo_empty;
   logic                  fifo_half;
   logic [DATA_WIDTH-1:0] fifo_data_out;
   logic                  fifo_rd_en;
   logic                  m_valid;
   logic [DATA_WIDTH-1:0] m_data;
   logic                  m_ready;

   modport master (
      input  fifo_empty, fifo_half, fifo_data_out, m_ready,
      output fifo_rd_en, m_valid, m_data
   );

   modport slave (
      output fifo_empty, fifo_half, fifo_data_out, m_ready,
      input  fifo_rd_en, m_valid, m_data
   );
endinterface

// File: rtl/fifo_rd_stream_adapter.sv
// Read-domain FIFO consumer: burst-gated reads into a 2-entry skid buffer feeding a valid/ready stream.
// Optional macro RD_STREAM_STATS_EN adds word_cnt/stall_cnt saturating counters.
module fifo_rd_stream_adapter #(
   parameter int DATA_WIDTH = 8,
   parameter int SKID_DEPTH = 2
) (
   input  logic clk_rd,
   input  logic rst_n,
   input  logic flush,
   output logic busy,
`ifdef RD_STREAM_STATS_EN
   output logic [31:0] word_cnt,
   output logic [15:0] stall_cnt,
`endif
   fifo_rd_stream_adapter_if.master bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      DRAIN  = 2'd2
   } state_t;

   state_t                state, state_nxt;
   logic                  inflight;
   logic [1:0]            occ;
   logic [DATA_WIDTH-1:0] head, tail;
   logic                  pop, capture, rd_en;
   logic [2:0]            credit_use;
   logic                  fifo_drained;

   assign pop          = (occ != 2'd0) && bus.m_ready;
   assign capture      = inflight;
   assign fifo_drained = bus.fifo_empty && !inflight;
   // Slots that will be taken next cycle if no new read is issued now.
   assign credit_use   = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};

   always_ff @(posedge clk_rd or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      rd_en     = 1'b0;
      unique case (state)
         IDLE: begin
            if (flush)              state_nxt = DRAIN;
            else if (bus.fifo_half) state_nxt = STREAM;
         end
         STREAM: begin
            if (flush)             state_nxt = DRAIN;
            else if (fifo_drained) state_nxt = IDLE;
         end
         DRAIN: begin
            if (fifo_drained && !flush) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      if (state != IDLE && !bus.fifo_empty && credit_use < 3'd2) rd_en = 1'b1;
   end

   always_ff @(posedge clk_rd or negedge rst_n) begin
      if (!rst_n) begin
         inflight <= 1'b0;
         occ      <= 2'd0;
         head     <= '0;
         tail     <= '0;
      end else begin
         inflight <= rd_en;
         unique case ({capture, pop})
            2'b10: begin
               if (occ == 2'd0) head <= bus.fifo_data_out;
               else             tail <= bus.fifo_data_out;
               occ <= occ + 2'd1;
            end
            2'b01: begin
               head <= tail;
               occ  <= occ - 2'd1;
            end
            2'b11: begin
               // Pop and capture together: occupancy holds, second entry moves up.
               if (occ == 2'd2) begin
                  head <= tail;
                  tail <= bus.fifo_data_out;
               end else begin
                  head <= bus.fifo_data_out;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.fifo_rd_en = rd_en;
   assign bus.m_valid    = (occ != 2'd0);
   assign bus.m_data     = head;
   assign busy           = (state != IDLE) || inflight || (occ != 2'd0);

`ifdef RD_STREAM_STATS_EN
   always_ff @(posedge clk_rd or negedge rst_n) begin
      if (!rst_n) begin
         word_cnt  <= '0;
         stall_cnt <= '0;
      end else begin
         if (pop && word_cnt != '1) word_cnt <= word_cnt + 32'd1;
         if (bus.m_valid && !bus.m_ready && stall_cnt != '1) stall_cnt <= stall_cnt + 16'd1;
      end
   end
`endif

   skid_depth_fixed: assert property (@(posedge clk_rd) SKID_DEPTH == 2);
   skid_no_overflow: assert property (@(posedge clk_rd) disable iff (!rst_n)
      !(capture && occ == 2'd2));
   no_rd_when_empty: assert property (@(posedge clk_rd) disable iff (!rst_n)
      !(rd_en && bus.fifo_empty));

endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// Directed bench for fifo_rd_stream_adapter: behavioural 1-cycle-latency FIFO, vector table,
// hand sequences for stall, reset mid-burst and (with RD_STREAM_STATS_EN) the counters.
module tb_fifo_rd_stream_adapter;

   logic clk_rd = 1'b0;
   logic rst_n  = 1'b0;
   logic flush  = 1'b0;
   logic busy;
`ifdef RD_STREAM_STATS_EN
   logic [31:0] word_cnt;
   logic [15:0] stall_cnt;
`endif

   fifo_rd_stream_adapter_if #(.DATA_WIDTH(8)) bus ();

   fifo_rd_stream_adapter #(.DATA_WIDTH(8), .SKID_DEPTH(2)) dut (
      .clk_rd    (clk_rd),
      .rst_n     (rst_n),
      .flush     (flush),
      .busy      (busy),
`ifdef RD_STREAM_STATS_EN
      .word_cnt  (word_cnt),
      .stall_cnt (stall_cnt),
`endif
      .bus       (bus)
   );

   always #5 clk_rd = ~clk_rd;

   // FIFO model: 64 deep, half at >= 32 words, data valid the cycle after rd_en.
   logic [7:0] mem [0:255];
   int push_cnt = 0;
   int pop_cnt  = 0;
   int cyc      = 0;
   assign bus.fifo_empty = (push_cnt == pop_cnt);
   assign bus.fifo_half  = (push_cnt - pop_cnt) >= 32;

   initial begin
      bus.fifo_data_out = 8'h00;
      forever begin
         @(posedge clk_rd);
         cyc <= cyc + 1;
         if (bus.fifo_rd_en && !bus.fifo_empty) begin
            bus.fifo_data_out <= mem[pop_cnt];
            pop_cnt <= pop_cnt + 1;
         end
      end
   end

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk_rd);
      #1;
   endtask

   task automatic push(input int n);
      for (int k = 0; k < n; k++) begin
         mem[push_cnt] = push_cnt[7:0];
         push_cnt++;
      end
   endtask

   // Stream monitor / scoreboard, sampled on the falling edge.
   int   exp_idx   = 0;
   int   delivered = 0;
   int   first_pop = -1;
   int   last_pop  = -1;
   logic bz        = 1'b1;

   initial begin
      logic       prev_stall = 1'b0;
      logic       prev_pop   = 1'b0;
      logic [7:0] prev_data  = 8'h00;
      forever begin
         @(negedge clk_rd);
         if (!rst_n) begin
            prev_stall = 1'b0;
            prev_pop   = 1'b0;
         end else begin
            if (prev_stall) begin
               chk("hold_valid", 32'(bus.m_valid), 32'd1);
               chk("hold_data", 32'(bus.m_data), 32'(prev_data));
            end
            if (bus.fifo_empty) chk("rd_en_while_empty", 32'(bus.fifo_rd_en), 32'd0);
            if (prev_pop) bz = busy;
            if (bus.m_valid && bus.m_ready) begin
               chk("stream_data", 32'(bus.m_data), 32'(exp_idx & 255));
               exp_idx++;
               delivered++;
               if (first_pop < 0) first_pop = cyc;
               last_pop = cyc;
            end
            prev_pop   = bus.m_valid && bus.m_ready;
            prev_stall = bus.m_valid && !bus.m_ready;
            prev_data  = bus.m_data;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   typedef struct {
      int   n_push;
      int   flush_cyc;
      int   wait_cyc;
      int   exp_deliv;
      int   exp_rd;
      logic exp_busy;
   } vec_t;

   initial begin
      vec_t vt [6];
      int d0, r0, base;
`ifdef RD_STREAM_STATS_EN
      int w0, s0;
`endif
      vt[0] = '{31, 0, 20,  0,  0, 1'b0};  // below half: nothing moves
      vt[1] = '{ 1, 0, 60, 32, 32, 1'b0};  // 32nd word reaches half: full burst
      vt[2] = '{ 5, 1, 30,  5,  5, 1'b0};  // flush pulse drains a short FIFO
      vt[3] = '{40, 0, 70, 40, 40, 1'b0};  // burst above half drains to empty
      vt[4] = '{ 1, 0, 20,  0,  0, 1'b0};  // lone word waits
      vt[5] = '{ 0, 1, 20,  1,  1, 1'b0};  // flush releases the lone word

      bus.m_ready = 1'b1;
      repeat (3) tick();
      chk("rst_rd_en", 32'(bus.fifo_rd_en), 32'd0);
      chk("rst_m_valid", 32'(bus.m_valid), 32'd0);
      chk("rst_m_data", 32'(bus.m_data), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      rst_n = 1'b1;
      tick();

      for (int i = 0; i < 6; i++) begin
         d0 = delivered;
         r0 = pop_cnt;
         first_pop = -1;
         bz = 1'b1;
         push(vt[i].n_push);
         if (vt[i].flush_cyc > 0) begin
            flush = 1'b1;
            repeat (vt[i].flush_cyc) tick();
            flush = 1'b0;
         end
         repeat (vt[i].wait_cyc) tick();
         chk($sformatf("vec%0d_delivered", i), delivered - d0, vt[i].exp_deliv);
         chk($sformatf("vec%0d_reads", i), pop_cnt - r0, vt[i].exp_rd);
         chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vt[i].exp_busy));
         if (vt[i].exp_deliv > 0) begin
            chk($sformatf("vec%0d_no_bubbles", i), last_pop - first_pop + 1, vt[i].exp_deliv);
            chk($sformatf("vec%0d_busy_after_last_pop", i), 32'(bz), 32'd0);
         end
      end

      // Backpressure: 10 cycles of m_ready=0 after a half-triggered burst.
      d0 = delivered;
      r0 = pop_cnt;
      base = push_cnt;
      bus.m_ready = 1'b0;
      push(32);
      repeat (10) tick();
      chk("stall_reads", pop_cnt - r0, 2);
      chk("stall_valid", 32'(bus.m_valid), 32'd1);
      chk("stall_head", 32'(bus.m_data), 32'(base & 255));
      chk("stall_rd_en", 32'(bus.fifo_rd_en), 32'd0);
      chk("stall_delivered", delivered - d0, 0);
      bus.m_ready = 1'b1;
      repeat (50) tick();
      chk("stall_resume_delivered", delivered - d0, 32);
      chk("stall_resume_busy", 32'(busy), 32'd0);

      // Reset with one word buffered and one in flight; both are lost.
      bus.m_ready = 1'b0;
      r0 = pop_cnt;
      push(32);
      repeat (3) tick();
      chk("pre_rst_reads", pop_cnt - r0, 2);
      chk("pre_rst_valid", 32'(bus.m_valid), 32'd1);
      chk("pre_rst_busy", 32'(busy), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_rd_en", 32'(bus.fifo_rd_en), 32'd0);
      chk("mid_rst_m_valid", 32'(bus.m_valid), 32'd0);
      chk("mid_rst_m_data", 32'(bus.m_data), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
`ifdef RD_STREAM_STATS_EN
      chk("mid_rst_word_cnt", word_cnt, 32'd0);
      chk("mid_rst_stall_cnt", 32'(stall_cnt), 32'd0);
`endif
      exp_idx += 2;
      repeat (2) tick();
      rst_n = 1'b1;
      d0 = delivered;
      r0 = pop_cnt;
      repeat (10) tick();
      chk("post_rst_idle_reads", pop_cnt - r0, 0);
      chk("post_rst_idle_delivered", delivered - d0, 0);
      flush = 1'b1;
      bus.m_ready = 1'b1;
      repeat (45) tick();
      chk("post_rst_flush_delivered", delivered - d0, 30);
      chk("drain_held_by_flush", 32'(busy), 32'd1);
      flush = 1'b0;
      repeat (2) tick();
      chk("drain_exit_busy", 32'(busy), 32'd0);

`ifdef RD_STREAM_STATS_EN
      w0 = int'(word_cnt);
      s0 = int'(stall_cnt);
      push(40);
      repeat (5) tick();
      bus.m_ready = 1'b0;
      repeat (7) tick();
      bus.m_ready = 1'b1;
      repeat (60) tick();
      chk("stats_word_cnt", int'(word_cnt) - w0, 40);
      chk("stats_stall_cnt", int'(stall_cnt) - s0, 7);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
